// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, FSM states, GF(2^8) helper and S-box table.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;
    localparam int KEYS_W     = (NUM_ROUNDS + 1) * BLOCK_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } aesState_t;

    // Entry for byte value v sits at bits [8*(255-v) +: 8]
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte i of a block is bits [127-8*i -: 8], column-major.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] stateIn,
    input  logic [BLOCK_W-1:0] roundKey,
    input  logic               lastRound,
    output logic [BLOCK_W-1:0] stateOut
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    for (genvar i = 0; i < 16; i++) begin : gSub
        assign sb[i] = sbox(stateIn[127-8*i -: 8]);
    end

    // Row r of the output takes column (c+r) mod 4 of the input
    for (genvar c = 0; c < 4; c++) begin : gCol
        for (genvar r = 0; r < 4; r++) begin : gRow
            assign sr[r+4*c] = sb[r+4*((c+r)%4)];
        end

        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*c];
        assign a1 = sr[4*c+1];
        assign a2 = sr[4*c+2];
        assign a3 = sr[4*c+3];

        assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    for (genvar i = 0; i < 16; i++) begin : gKey
        assign stateOut[127-8*i -: 8] =
            (lastRound ? sr[i] : mc[i]) ^ roundKey[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core, one round per clock, valid/ready I/O.
// Define AES_KEY_LATCH_EN to register the round keys on accept.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] dataIn,
    input  logic [KEYS_W-1:0]  keysIn,
    input  logic               inValid,
    output logic               inReady,
    output logic [BLOCK_W-1:0] dataOut,
    output logic               outValid,
    input  logic               outReady,
    output logic               busy
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    aesState_t fsm, fsmNext;
    logic [3:0] roundCnt;
    logic [BLOCK_W-1:0] state;
    logic [BLOCK_W-1:0] roundOut;
    logic [KEYS_W-1:0] keySrc;
    logic [NUM_ROUNDS:0][BLOCK_W-1:0] keyArr;
    logic cntOk;
    logic lastRound;

`ifdef AES_KEY_LATCH_EN
    logic [KEYS_W-1:0] keyReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            keyReg <= '0;
        end else if (fsm == IDLE && inValid) begin
            keyReg <= keysIn;
        end
    end

    assign keySrc = keyReg;
`else
    assign keySrc = keysIn;
`endif

    assign keyArr    = keySrc;
    assign cntOk     = (roundCnt != 4'd0) && (roundCnt <= LAST);
    assign lastRound = (roundCnt == LAST);

    aes_round uRound (
        .stateIn  (state),
        .roundKey (keyArr[roundCnt]),
        .lastRound(lastRound),
        .stateOut (roundOut)
    );

    always_comb begin
        fsmNext  = fsm;
        inReady  = 1'b0;
        outValid = 1'b0;
        busy     = 1'b0;
        unique case (fsm)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) fsmNext = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (!cntOk) fsmNext = IDLE;
                else if (lastRound) fsmNext = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                outValid = 1'b1;
                if (outReady) fsmNext = IDLE;
            end
            default: fsmNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= IDLE;
            roundCnt <= '0;
            state    <= '0;
            dataOut  <= '0;
        end else begin
            fsm <= fsmNext;
            unique case (fsm)
                IDLE: begin
                    if (inValid) begin
                        state    <= dataIn ^ keysIn[BLOCK_W-1:0];
                        roundCnt <= 4'd1;
                    end
                end
                RUN: begin
                    if (!cntOk) begin
                        roundCnt <= '0;
                    end else if (lastRound) begin
                        state    <= roundOut;
                        dataOut  <= roundOut;
                        roundCnt <= '0;
                    end else begin
                        state    <= roundOut;
                        roundCnt <= roundCnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, handshakes,
// reset cases and random blocks against a byte-level AES reference.
module tb_aes_encrypt_iter;

    logic clk = 1'b0;
    logic reset;
    logic [127:0] dataIn;
    logic [1407:0] keysIn;
    logic inValid;
    logic inReady;
    logic [127:0] dataOut;
    logic outValid;
    logic outReady;
    logic busy;

    int total = 0;
    int bad = 0;

    logic [7:0] sboxTab [256];

    always #5 clk = ~clk;

    aes_encrypt_iter dut (
        .clk     (clk),
        .reset   (reset),
        .dataIn  (dataIn),
        .keysIn  (keysIn),
        .inValid (inValid),
        .inReady (inReady),
        .dataOut (dataOut),
        .outValid(outValid),
        .outReady(outReady),
        .busy    (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = (x << n) | (x >> (8 - n));
        return y;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic buildSbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int a = 1; a < 256; a++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(a);
            end
            sboxTab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                       ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expandKey(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1407:0] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]],
                     sboxTab[t[15:8]], sboxTab[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        ks = '0;
        for (int r = 0; r < 11; r++)
            ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] refEncrypt(input logic [127:0] pt,
                                                input logic [1407:0] ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w+4*c] = sboxTab[s[w+4*((c+w)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r+127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runBlock(input logic [127:0] pt, input logic [1407:0] ks,
                            input logic zap, output int lat);
        int n;
        dataIn = pt;
        keysIn = ks;
        inValid = 1'b1;
        n = 0;
        while (!inReady && n < 50) begin
            tick();
            n++;
        end
        chk("acceptReady", 128'(inReady), 128'd1);
        tick();
        inValid = 1'b0;
        if (zap) keysIn = '0;
        lat = 0;
        while (!outValid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [1407:0] ksB, ksC, ksR;
        logic [127:0] pt, key;
        logic acc;
        int lat;
        int accCyc [$];
        logic [127:0] results [$];
        logic switched;

        buildSbox();
        ksB = expandKey(KEY_B);
        ksC = expandKey(KEY_C);

        reset = 1'b1;
        dataIn = '0;
        keysIn = '0;
        inValid = 1'b0;
        outReady = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rstOutValid", 128'(outValid), 128'd0);
        chk("rstDataOut", dataOut, 128'd0);
        chk("rstInReady", 128'(inReady), 128'd1);
        chk("rstBusy", 128'(busy), 128'd0);

        runBlock(PT_B, ksB, 1'b0, lat);
        chk("latB", 128'(lat), 128'd10);
        chk("ctB", dataOut, CT_B);

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bpValid", 128'(outValid), 128'd1);
            chk("bpData", dataOut, CT_B);
            chk("bpInReady", 128'(inReady), 128'd0);
        end
        chk("bpBusy", 128'(busy), 128'd1);
        outReady = 1'b1;
        tick();
        chk("relInReady", 128'(inReady), 128'd1);
        chk("relOutValid", 128'(outValid), 128'd0);

        runBlock(PT_C, ksC, 1'b0, lat);
        chk("latC", 128'(lat), 128'd10);
        chk("ctC", dataOut, CT_C);

        for (int k = 0; k < 6; k++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            ksR = expandKey(key);
            runBlock(pt, ksR, 1'b0, lat);
            chk("latRand", 128'(lat), 128'd10);
            chk("ctRand", dataOut, refEncrypt(pt, ksR));
        end
        tick();

        dataIn = PT_B;
        keysIn = ksB;
        inValid = 1'b1;
        switched = 1'b0;
        for (int cyc = 0; cyc < 60 && results.size() < 2; cyc++) begin
            acc = inReady && inValid;
            if (outValid && outReady) begin
                results.push_back(dataOut);
                if (!switched) begin
                    dataIn = PT_C;
                    keysIn = ksC;
                    switched = 1'b1;
                end
            end
            tick();
            if (acc) accCyc.push_back(cyc);
        end
        inValid = 1'b0;
        tick();
        chk("b2bCount", 128'(results.size()), 128'd2);
        chk("b2bFirst", results[0], CT_B);
        chk("b2bSecond", results[1], CT_C);
        chk("b2bSpacing", 128'(accCyc[1] - accCyc[0]), 128'd12);

        dataIn = PT_B;
        keysIn = ksB;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midRunBusy", 128'(busy), 128'd1);
        reset = 1'b1;
        tick();
        chk("midRstOutValid", 128'(outValid), 128'd0);
        chk("midRstDataOut", dataOut, 128'd0);
        chk("midRstInReady", 128'(inReady), 128'd1);
        inValid = 1'b1;
        tick();
        chk("rstWinsBusy", 128'(busy), 128'd0);
        reset = 1'b0;
        inValid = 1'b0;
        tick();
        chk("rstWinsIdle", 128'(busy), 128'd0);

        runBlock(PT_B, ksB, 1'b0, lat);
        chk("latAfterRst", 128'(lat), 128'd10);
        chk("ctAfterRst", dataOut, CT_B);

`ifdef AES_KEY_LATCH_EN
        tick();
        runBlock(PT_B, ksB, 1'b1, lat);
        chk("latLatch", 128'(lat), 128'd10);
        chk("ctLatch", dataOut, CT_B);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative AES-128 encryption core that sits directly downstream of the key-expansion block: it consumes the flattened 11-round-key bus and encrypts one 128-bit block at a time, one AES round per clock. Blocks enter and leave through valid/ready handshakes, so the core can sit between a plaintext source and a ciphertext sink with back-pressure on both sides.

## Interface
- NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is supported.
- KEYS_W, 1408, width of the round-key bus (11 × 128).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  128  plaintext block; bit 127 is state byte 0; bytes are column-major.
- keysIn  input  1408  round keys; round key r = keysIn[128*r+127 -: 128], with key 0 in [127:0].
- inValid  input  1  dataIn (and keysIn) presented.
- inReady  output  1  core can accept a block.
- dataOut  output  128  ciphertext block, same byte order as dataIn.
- outValid  output  1  dataOut holds a finished block.
- outReady  input  1  sink accepts dataOut.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - inReady=1.
  - On inValid: state ← dataIn ^ key0, roundCnt ← 1, go to RUN.
- RUN:
  - Each cycle: state ← Round(state, key[roundCnt]), roundCnt ← roundCnt+1.
  - Round = SubBytes → ShiftRows → MixColumns → AddRoundKey.
  - MixColumns is skipped when roundCnt==10.
  - After round 10: dataOut ← result, go to DONE.
- DONE:
  - outValid=1; dataOut is held stable.
  - On outReady: go to IDLE.
  - inReady=0 throughout DONE; there is no overlap of blocks.
- roundCnt:
  - 4-bit, range 1..10; 0 in IDLE.
  - Values 11–15 are unreachable; if one is ever reached, the FSM goes to IDLE.
- Arithmetic:
  - MixColumns in GF(2^8) with polynomial 0x11B.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- keysIn must be stable from the accept edge until the transition to DONE, unless AES_KEY_LATCH_EN is defined.
- inValid while busy is ignored; the source must hold it, per the handshake.

## Timing
- Reset values:
  - FSM = IDLE, roundCnt = 0, state = 0, dataOut = 0.
  - outValid = 0, busy = 0, inReady = 1 (first cycle after reset deasserts).
- Latency: accept edge at T → outValid high in the cycle after edge T+10 (10 cycles).
- Throughput: outReady constantly high gives one block per 12 cycles; the next accept can occur at the earliest at edge T+12.
- Handshakes: a transfer occurs on an edge where valid && ready.
  - outValid stays high, and dataOut unchanged, until outReady is sampled high.
- Reset mid-operation (RUN or DONE):
  - The block is discarded and all outputs return to reset values on the next edge.
  - No partial dataOut is ever presented with outValid=1.
- Simultaneous reset and inValid: reset wins and nothing is accepted.
- outReady held low indefinitely: the core stalls in DONE with dataOut held.

## Configuration
- AES_KEY_LATCH_EN defined:
  - keysIn is registered into an internal 1408-bit copy on the accept edge, and all rounds use the copy.
  - keysIn may change freely after acceptance, at the cost of 1408 flops.
- Undefined:
  - Rounds index keysIn directly, and the stability rule in Operation applies.
  - Timing is identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - NUM_ROUNDS, BLOCK_W=128, KEYS_W.
  - The FSM state enum.
  - An xtime function.
  - The S-box table, which is also used by key expansion.
- One combinational sub-module, aes_round:
  - Inputs: stateIn, roundKey, lastRound.
  - Output: stateOut.
  - Built from 16 S-box instances plus ShiftRows, MixColumns and AddRoundKey.

## Test plan
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, expanded by key expansion, with plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: dataOut 3925841d02dc09fbdc118597196a0b32, with outValid rising exactly 10 cycles after accept.
- FIPS-197 C.1:
  - Stimulus: key 000102…0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: dataOut 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure:
  - Stimulus: outReady low for 20 cycles after completion.
  - Required: outValid and dataOut stable, inReady=0; one cycle after outReady rises, inReady=1.
- Back-to-back:
  - Stimulus: inValid and outReady held high, two blocks (B vector, then C.1 vector).
  - Required: both results correct; accepts 12 cycles apart.
- Reset mid-RUN:
  - Stimulus: assert reset at round 5.
  - Required: the next cycle shows outValid=0, dataOut=0, inReady=1; a fresh Appendix B run still yields 3925841d….
- With AES_KEY_LATCH_EN:
  - Stimulus: zero keysIn one cycle after accept.
  - Required: ciphertext remains 3925841d02dc09fbdc118597196a0b32.
